// File: rtl/dumbrv_work_issue.sv
// rtl/dumbrv_work_issue.sv - load/store command issue with WAW scoreboard and in-order writeback
module dumbrv_work_issue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RBITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_opcode,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_data,
  input  logic [RBITS-1:0]      in_dreg,
  output logic                  in_ready,
  output logic                  mem_valid,
  output logic [3:0]            mem_opcode,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_data,
  input  logic                  mem_ready,
  input  logic                  rsp_valid,
  input  logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_ready,
  output logic                  wb_valid,
  output logic [RBITS-1:0]      wb_dreg,
  output logic [XLEN-1:0]       wb_data,
  input  logic                  wb_done,
  output logic [(1<<RBITS)-1:0] busy_mask,
  output logic                  idle,
  output logic                  err
);
  localparam int NREG = 1 << RBITS;
  localparam int PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [3:0]       cq_op_q   [DEPTH];
  logic [XLEN-1:0]  cq_addr_q [DEPTH];
  logic [XLEN-1:0]  cq_data_q [DEPTH];
  logic [RBITS-1:0] cq_dreg_q [DEPTH];
  logic [RBITS-1:0] tq_dreg_q [DEPTH];

  logic [PW-1:0]    cq_wp_q, cq_rp_q, tq_wp_q, tq_rp_q;
  logic [PW:0]      cq_cnt_q, cq_cnt_d, tq_cnt_q, tq_cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RBITS-1:0] wb_dreg_q, wb_dreg_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  logic in_is_load, waw, push, head_is_load, issue, trk_push, rsp_hs, wb_fire;
  logic [RBITS-1:0] rsp_dreg;

  assign in_is_load   = !in_opcode[3];
  assign waw          = in_is_load && (in_dreg != '0) && busy_q[in_dreg];
  assign in_ready     = !rst && (cq_cnt_q != FULL_CNT) && !waw;
  assign push         = in_valid && in_ready;

  // Head fields come straight from storage, so mem_valid never sees in_valid combinationally.
  assign head_is_load = !cq_op_q[cq_rp_q][3];
  assign mem_valid    = (cq_cnt_q != '0) && (!head_is_load || (tq_cnt_q != FULL_CNT));
  assign mem_opcode   = cq_op_q[cq_rp_q];
  assign mem_addr     = cq_addr_q[cq_rp_q];
  assign mem_data     = cq_data_q[cq_rp_q];
  assign issue        = mem_valid && mem_ready;
  assign trk_push     = issue && head_is_load;

  assign rsp_ready    = (tq_cnt_q != '0) && (!wb_valid_q || wb_done);
  assign rsp_hs       = rsp_valid && rsp_ready;
  assign rsp_dreg     = tq_dreg_q[tq_rp_q];
  assign wb_fire      = wb_valid_q && wb_done;

  assign wb_valid     = wb_valid_q;
  assign wb_dreg      = wb_dreg_q;
  assign wb_data      = wb_data_q;
  assign busy_mask    = busy_q;
  assign err          = err_q;
  assign idle         = (cq_cnt_q == '0) && (tq_cnt_q == '0) && !wb_valid_q;

  always_comb begin
    cq_cnt_d   = cq_cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, issue};
    tq_cnt_d   = tq_cnt_q + {{PW{1'b0}}, trk_push} - {{PW{1'b0}}, rsp_hs};
    busy_d     = busy_q;
    wb_valid_d = wb_valid_q;
    wb_dreg_d  = wb_dreg_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q | (rsp_valid && (tq_cnt_q == '0));
    if (wb_fire) begin
      busy_d[wb_dreg_q] = 1'b0;
      wb_valid_d        = 1'b0;
    end
    if (push && in_is_load && (in_dreg != '0)) busy_d[in_dreg] = 1'b1;
    // Register-0 loads drain their response without occupying the writeback slot.
    if (rsp_hs && (rsp_dreg != '0)) begin
      wb_valid_d = 1'b1;
      wb_dreg_d  = rsp_dreg;
      wb_data_d  = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_wp_q    <= '0;
      cq_rp_q    <= '0;
      cq_cnt_q   <= '0;
      tq_wp_q    <= '0;
      tq_rp_q    <= '0;
      tq_cnt_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_dreg_q  <= '0;
      wb_data_q  <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push)     cq_wp_q <= cq_wp_q + 1'b1;
      if (issue)    cq_rp_q <= cq_rp_q + 1'b1;
      if (trk_push) tq_wp_q <= tq_wp_q + 1'b1;
      if (rsp_hs)   tq_rp_q <= tq_rp_q + 1'b1;
      cq_cnt_q   <= cq_cnt_d;
      tq_cnt_q   <= tq_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_dreg_q  <= wb_dreg_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cq_op_q[cq_wp_q]   <= in_opcode;
      cq_addr_q[cq_wp_q] <= in_addr;
      cq_data_q[cq_wp_q] <= in_data;
      cq_dreg_q[cq_wp_q] <= in_dreg;
    end
    if (trk_push) tq_dreg_q[tq_wp_q] <= cq_dreg_q[cq_rp_q];
  end
endmodule

// File: tb/tb_dumbrv_work_issue.sv
// tb/tb_dumbrv_work_issue.sv - bench for dumbrv_work_issue
module tb_dumbrv_work_issue;
  localparam int XLEN = 32, DEPTH = 4, RBITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, mem_valid, mem_ready, rsp_valid, rsp_ready;
  logic wb_valid, wb_done, idle, err;
  logic [3:0] in_opcode, mem_opcode, in_dreg, wb_dreg;
  logic [31:0] in_addr, in_data, mem_addr, mem_data, rsp_data, wb_data;
  logic [15:0] busy_mask;

  int nvec = 0, nerr = 0;

  dumbrv_work_issue #(.XLEN(XLEN), .DEPTH(DEPTH), .RBITS(RBITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_addr(in_addr), .in_data(in_data),
    .in_dreg(in_dreg), .in_ready(in_ready),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .wb_valid(wb_valid), .wb_dreg(wb_dreg), .wb_data(wb_data), .wb_done(wb_done),
    .busy_mask(busy_mask), .idle(idle), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    in_valid = 0; in_opcode = 0; in_addr = 0; in_data = 0; in_dreg = 0;
    mem_ready = 0; rsp_valid = 0; rsp_data = 0; wb_done = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs(); in_valid = 1; in_opcode = 4'h8;
    tick(); tick(); #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    nvec++; if (mem_valid !== 1'b0) begin nerr++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    nvec++; if (rsp_ready !== 1'b0) begin nerr++; $display("FAIL rst_rsp_ready: got %b want 0", rsp_ready); end
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL rst_idle: got %b want 1", idle); end
    nvec++; if (busy_mask !== 16'h0) begin nerr++; $display("FAIL rst_busy: got %h want 0", busy_mask); end
    nvec++; if (err !== 1'b0 || wb_valid !== 1'b0) begin nerr++; $display("FAIL rst_err_wb: got %b%b want 00", err, wb_valid); end
    in_valid = 0; rst = 0; tick();
  endtask

  task automatic test_single_load;
    in_valid = 1; in_opcode = 4'h0; in_addr = 32'h100; in_dreg = 5; mem_ready = 1; wb_done = 1; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t1_in_ready: got %b want 1", in_ready); end
    nvec++; if (mem_valid !== 1'b0) begin nerr++; $display("FAIL t1_no_comb_path: got %b want 0", mem_valid); end
    tick(); in_valid = 0; #1;
    nvec++; if (busy_mask !== 16'h0020) begin nerr++; $display("FAIL t1_busy_set: got %h want 0020", busy_mask); end
    nvec++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin nerr++; $display("FAIL t1_mem_req: got %b/%h want 1/00000100", mem_valid, mem_addr); end
    tick(); #1;
    nvec++; if (mem_valid !== 1'b0) begin nerr++; $display("FAIL t1_issued: got %b want 0", mem_valid); end
    tick(); rsp_valid = 1; rsp_data = 32'hDEADBEEF; #1;
    nvec++; if (rsp_ready !== 1'b1) begin nerr++; $display("FAIL t1_rsp_ready: got %b want 1", rsp_ready); end
    tick(); rsp_valid = 0; #1;
    nvec++; if (wb_valid !== 1'b1 || wb_dreg !== 4'd5 || wb_data !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL t1_wb: got %b/%0d/%h want 1/5/deadbeef", wb_valid, wb_dreg, wb_data); end
    tick(); #1;
    nvec++; if (busy_mask !== 16'h0 || wb_valid !== 1'b0 || idle !== 1'b1) begin
      nerr++; $display("FAIL t1_done: got busy %h wb %b idle %b want 0000 0 1", busy_mask, wb_valid, idle); end
    idle_inputs();
  endtask

  task automatic test_fill;
    logic [31:0] fd [4];
    logic [31:0] d5;
    bit acc5;
    acc5 = 0; d5 = $urandom;
    for (int i = 0; i < 4; i++) begin
      fd[i] = $urandom;
      in_valid = 1; in_opcode = 4'h8 | 4'(i); in_addr = 32'h200 + 32'(4 * i); in_data = fd[i]; #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t2_push%0d: got %b want 1", i, in_ready); end
      tick();
    end
    in_opcode = 4'hF; in_addr = 32'h2F0; in_data = d5; #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL t2_full: got %b want 0", in_ready); end
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 + 32'(4 * i) || mem_data !== fd[i]) begin
        nerr++; $display("FAIL t2_issue%0d: got %b/%h/%h want 1/%h/%h", i, mem_valid, mem_addr, mem_data, 32'h200 + 32'(4 * i), fd[i]); end
      if (i == 0) begin
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL t2_fifth_held: got %b want 0", in_ready); end
      end
      if (in_valid && in_ready) acc5 = 1;
      tick();
      if (acc5) in_valid = 0;
    end
    #1;
    nvec++; if (mem_valid !== 1'b1 || mem_addr !== 32'h2F0 || mem_data !== d5) begin
      nerr++; $display("FAIL t2_fifth: got %b/%h/%h want 1/000002f0/%h", mem_valid, mem_addr, mem_data, d5); end
    tick(); #1;
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL t2_idle: got %b want 1", idle); end
    idle_inputs();
  endtask

  task automatic test_waw;
    mem_ready = 1; wb_done = 0;
    in_valid = 1; in_opcode = 4'h0; in_dreg = 3; in_addr = 32'h300; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t3_first: got %b want 1", in_ready); end
    tick(); #1;
    nvec++; if (in_ready !== 1'b0 || busy_mask !== 16'h0008) begin nerr++; $display("FAIL t3_stall: got %b/%h want 0/0008", in_ready, busy_mask); end
    tick(); in_opcode = 4'h8; in_addr = 32'h310; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t3_store_ok: got %b want 1", in_ready); end
    tick(); in_opcode = 4'h0; in_dreg = 4; in_addr = 32'h340; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t3_r4_ok: got %b want 1", in_ready); end
    tick(); in_dreg = 3; in_addr = 32'h350; rsp_valid = 1; rsp_data = 32'h3333; #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL t3_stall2: got %b want 0", in_ready); end
    tick(); rsp_data = 32'h4444; #1;
    nvec++; if (wb_valid !== 1'b1 || wb_dreg !== 4'd3 || wb_data !== 32'h3333 || rsp_ready !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL t3_wb3: got %b/%0d/%h rr %b ir %b want 1/3/00003333 0 0", wb_valid, wb_dreg, wb_data, rsp_ready, in_ready); end
    tick(); wb_done = 1; #1;
    nvec++; if (in_ready !== 1'b0 || rsp_ready !== 1'b1) begin nerr++; $display("FAIL t3_preclear: got ir %b rr %b want 0 1", in_ready, rsp_ready); end
    tick(); rsp_valid = 0; #1;
    nvec++; if (in_ready !== 1'b1 || wb_dreg !== 4'd4 || wb_data !== 32'h4444 || busy_mask !== 16'h0010) begin
      nerr++; $display("FAIL t3_after_wb: got ir %b %0d/%h busy %h want 1 4/00004444 0010", in_ready, wb_dreg, wb_data, busy_mask); end
    tick(); in_valid = 0; #1;
    nvec++; if (busy_mask !== 16'h0008 || wb_valid !== 1'b0) begin nerr++; $display("FAIL t3_reissue: got %h/%b want 0008/0", busy_mask, wb_valid); end
    tick(); rsp_valid = 1; rsp_data = 32'h5555;
    tick(); rsp_valid = 0; #1;
    nvec++; if (wb_valid !== 1'b1 || wb_dreg !== 4'd3 || wb_data !== 32'h5555) begin
      nerr++; $display("FAIL t3_wb3b: got %b/%0d/%h want 1/3/00005555", wb_valid, wb_dreg, wb_data); end
    tick(); #1;
    nvec++; if (idle !== 1'b1 || busy_mask !== 16'h0) begin nerr++; $display("FAIL t3_idle: got %b/%h want 1/0000", idle, busy_mask); end
    idle_inputs();
  endtask

  task automatic test_wb_backpressure;
    mem_ready = 1; wb_done = 0;
    in_valid = 1; in_opcode = 4'h0; in_dreg = 1; in_addr = 32'h410; tick();
    in_dreg = 2; in_addr = 32'h420; tick();
    in_valid = 0; tick();
    rsp_valid = 1; rsp_data = 32'hA1; #1;
    nvec++; if (rsp_ready !== 1'b1) begin nerr++; $display("FAIL t4_rsp1: got %b want 1", rsp_ready); end
    tick(); rsp_data = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (rsp_ready !== 1'b0 || wb_valid !== 1'b1 || wb_dreg !== 4'd1 || wb_data !== 32'hA1) begin
        nerr++; $display("FAIL t4_hold%0d: got rr %b %b/%0d/%h want 0 1/1/000000a1", i, rsp_ready, wb_valid, wb_dreg, wb_data); end
      tick();
    end
    wb_done = 1; #1;
    nvec++; if (rsp_ready !== 1'b1) begin nerr++; $display("FAIL t4_release: got %b want 1", rsp_ready); end
    tick(); rsp_valid = 0; #1;
    nvec++; if (wb_valid !== 1'b1 || wb_dreg !== 4'd2 || wb_data !== 32'hA2 || busy_mask !== 16'h0004) begin
      nerr++; $display("FAIL t4_wb2: got %b/%0d/%h busy %h want 1/2/000000a2 0004", wb_valid, wb_dreg, wb_data, busy_mask); end
    tick(); #1;
    nvec++; if (idle !== 1'b1 || busy_mask !== 16'h0) begin nerr++; $display("FAIL t4_idle: got %b/%h want 1/0000", idle, busy_mask); end
    idle_inputs();
  endtask

  task automatic test_random;
    logic [3:0] q_op[$], q_dreg[$], r_dreg[$];
    logic [31:0] q_addr[$], q_data[$], r_data[$];
    logic [15:0] mbusy;
    logic [3:0] c_op, c_dreg, slot_r;
    logic [31:0] c_addr, c_data, slot_d;
    logic slot_v, exp_rdy, exp_mv, exp_rr, exp_idle;
    bit new_cmd, drain, acc, iss, rhs, wbf;
    mbusy = 0; slot_v = 0; slot_r = 0; slot_d = 0; new_cmd = 1;
    c_op = 0; c_dreg = 0; c_addr = 0; c_data = 0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      drain = (cyc >= 1500);
      if (new_cmd) begin
        c_op = 4'($urandom); c_addr = $urandom; c_data = $urandom; c_dreg = 4'($urandom_range(0, 5)); new_cmd = 0;
      end
      in_valid = !drain && ($urandom_range(0, 3) != 0);
      in_opcode = c_op; in_addr = c_addr; in_data = c_data; in_dreg = c_dreg;
      mem_ready = drain || ($urandom_range(0, 2) != 0);
      wb_done = drain || ($urandom_range(0, 2) != 0);
      rsp_valid = (r_data.size() > 0) && (drain || ($urandom_range(0, 1) != 0));
      rsp_data = (r_data.size() > 0) ? r_data[0] : $urandom;
      #1;
      exp_rdy = (q_op.size() < DEPTH) && !(!c_op[3] && c_dreg != 0 && mbusy[c_dreg]);
      exp_mv = (q_op.size() > 0) && (q_op[0][3] || r_data.size() < DEPTH);
      exp_rr = (r_data.size() > 0) && (!slot_v || wb_done);
      exp_idle = (q_op.size() == 0) && (r_data.size() == 0) && !slot_v;
      nvec++; if (in_ready !== exp_rdy) begin nerr++; if (nerr < 40) $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      nvec++; if (mem_valid !== exp_mv) begin nerr++; if (nerr < 40) $display("FAIL rnd_mem_valid c%0d: got %b want %b", cyc, mem_valid, exp_mv); end
      nvec++; if (rsp_ready !== exp_rr) begin nerr++; if (nerr < 40) $display("FAIL rnd_rsp_ready c%0d: got %b want %b", cyc, rsp_ready, exp_rr); end
      nvec++; if (busy_mask !== mbusy) begin nerr++; if (nerr < 40) $display("FAIL rnd_busy c%0d: got %h want %h", cyc, busy_mask, mbusy); end
      nvec++; if (wb_valid !== slot_v || idle !== exp_idle || err !== 1'b0) begin
        nerr++; if (nerr < 40) $display("FAIL rnd_status c%0d: got wb %b idle %b err %b want %b %b 0", cyc, wb_valid, idle, err, slot_v, exp_idle); end
      if (slot_v) begin
        nvec++; if (wb_dreg !== slot_r || wb_data !== slot_d) begin
          nerr++; if (nerr < 40) $display("FAIL rnd_wb c%0d: got %0d/%h want %0d/%h", cyc, wb_dreg, wb_data, slot_r, slot_d); end
      end
      if (exp_mv) begin
        nvec++; if (mem_opcode !== q_op[0] || mem_addr !== q_addr[0] || mem_data !== q_data[0]) begin
          nerr++; if (nerr < 40) $display("FAIL rnd_mem c%0d: got %h/%h/%h want %h/%h/%h", cyc, mem_opcode, mem_addr, mem_data, q_op[0], q_addr[0], q_data[0]); end
      end
      acc = in_valid && exp_rdy; iss = exp_mv && mem_ready; rhs = rsp_valid && exp_rr; wbf = slot_v && wb_done;
      @(posedge clk);
      if (iss) begin
        if (!q_op[0][3]) begin r_data.push_back($urandom); r_dreg.push_back(q_dreg[0]); end
        void'(q_op.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_dreg.pop_front());
      end
      if (wbf) begin mbusy[slot_r] = 1'b0; slot_v = 0; end
      if (rhs) begin
        if (r_dreg[0] != 0) begin slot_v = 1; slot_r = r_dreg[0]; slot_d = r_data[0]; end
        void'(r_data.pop_front()); void'(r_dreg.pop_front());
      end
      if (acc) begin
        q_op.push_back(c_op); q_addr.push_back(c_addr); q_data.push_back(c_data); q_dreg.push_back(c_dreg);
        if (!c_op[3] && c_dreg != 0) mbusy[c_dreg] = 1'b1;
        new_cmd = 1;
      end
      @(negedge clk);
    end
    #1;
    nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL rnd_drain_idle: got %b want 1", idle); end
    idle_inputs();
  endtask

  task automatic test_err_zero;
    mem_ready = 1; wb_done = 1;
    in_valid = 1; in_opcode = 4'h0; in_dreg = 0; in_addr = 32'h500; #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL t5_r0_push: got %b want 1", in_ready); end
    tick(); in_valid = 0; #1;
    nvec++; if (busy_mask !== 16'h0 || mem_valid !== 1'b1) begin nerr++; $display("FAIL t5_r0_busy: got %h/%b want 0000/1", busy_mask, mem_valid); end
    tick(); rsp_valid = 1; rsp_data = 32'h77; #1;
    nvec++; if (rsp_ready !== 1'b1) begin nerr++; $display("FAIL t5_r0_rsp: got %b want 1", rsp_ready); end
    tick(); rsp_valid = 0; #1;
    nvec++; if (wb_valid !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin
      nerr++; $display("FAIL t5_r0_nowb: got wb %b idle %b err %b want 0 1 0", wb_valid, idle, err); end
    rsp_valid = 1; #1;
    nvec++; if (rsp_ready !== 1'b0) begin nerr++; $display("FAIL t5_empty_rr: got %b want 0", rsp_ready); end
    tick(); rsp_valid = 0; #1;
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL t5_err: got %b want 1", err); end
    tick(); tick(); #1;
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL t5_err_sticky: got %b want 1", err); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight;
    in_valid = 1; in_opcode = 4'h0; in_dreg = 6; in_addr = 32'h600; mem_ready = 0; tick();
    in_opcode = 4'h8; in_addr = 32'h610; mem_ready = 1; tick();
    mem_ready = 0; in_addr = 32'h620; tick();
    in_addr = 32'h630; tick();
    in_valid = 0; #1;
    nvec++; if (busy_mask !== 16'h0040 || idle !== 1'b0 || mem_valid !== 1'b1) begin
      nerr++; $display("FAIL t6_loaded: got %h/%b/%b want 0040/0/1", busy_mask, idle, mem_valid); end
    rst = 1; tick(); rst = 0; #1;
    nvec++; if (idle !== 1'b1 || busy_mask !== 16'h0 || mem_valid !== 1'b0 || rsp_ready !== 1'b0 || err !== 1'b0) begin
      nerr++; $display("FAIL t6_cleared: got idle %b busy %h mv %b rr %b err %b want 1 0000 0 0 0", idle, busy_mask, mem_valid, rsp_ready, err); end
    rsp_valid = 1; tick(); rsp_valid = 0; #1;
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL t6_late_rsp_err: got %b want 1", err); end
    idle_inputs();
  endtask

  initial begin
    rst = 1; idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_load();
    test_fill();
    test_waw();
    test_wb_backpressure();
    test_random();
    test_err_zero();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
